// File: rtl/pipeline_sequencer.sv
// Pipeline run-control sequencer: load / run / single-step / drain / halt.
// Optional macro CYCLE_COUNTER_EN adds a saturating enabled-cycle counter.
module pipeline_sequencer #(
    parameter int                 NB_OP        = 6,
    parameter logic [NB_OP-1:0]   HALT_OPCODE  = {NB_OP{1'b1}},
    parameter int                 DRAIN_CYCLES = 4,
    parameter int                 NB_COUNT     = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load_req,
    input  logic                load_done,
    input  logic                start_run,
    input  logic                step_req,
    input  logic [NB_OP-1:0]    opcode_id,
    output logic                pipe_enable,
    output logic                pc_halt,
    output logic                halted,
    output logic [2:0]          state_o,
    output logic [NB_COUNT-1:0] cycle_count
);

    localparam logic [2:0] S_IDLE      = 3'b000;
    localparam logic [2:0] S_LOAD      = 3'b001;
    localparam logic [2:0] S_RUN       = 3'b010;
    localparam logic [2:0] S_STEP_EXEC = 3'b011;
    localparam logic [2:0] S_STEP_WAIT = 3'b100;
    localparam logic [2:0] S_DRAIN     = 3'b101;
    localparam logic [2:0] S_HALTED    = 3'b110;

    // Drain counter counts down to zero, so it starts one below the length.
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [3:0] drain_cnt;
    logic [3:0] drain_cnt_nxt;
    logic       is_halt;

    assign is_halt = (opcode_id == HALT_OPCODE);

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            S_IDLE: begin
                if (load_req)       state_nxt = S_LOAD;
                else if (start_run) state_nxt = S_RUN;
                else if (step_req)  state_nxt = S_STEP_EXEC;
            end
            S_LOAD: begin
                if (load_done) state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (is_halt) begin
                    state_nxt     = S_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            S_STEP_EXEC: begin
                if (is_halt) begin
                    state_nxt     = S_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end else begin
                    state_nxt = S_STEP_WAIT;
                end
            end
            S_STEP_WAIT: begin
                if (load_req)       state_nxt = S_LOAD;
                else if (start_run) state_nxt = S_RUN;
                else if (step_req)  state_nxt = S_STEP_EXEC;
            end
            S_DRAIN: begin
                if (drain_cnt == 4'd0) state_nxt = S_HALTED;
                else                   drain_cnt_nxt = drain_cnt - 4'd1;
            end
            S_HALTED: begin
                if (load_req) state_nxt = S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            drain_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Outputs are pure decodes of the state register.
    always_comb begin
        pipe_enable = (state == S_RUN) || (state == S_STEP_EXEC) || (state == S_DRAIN);
        pc_halt     = (state == S_DRAIN) || (state == S_HALTED);
        halted      = (state == S_HALTED);
        state_o     = state;
    end

`ifdef CYCLE_COUNTER_EN
    logic [NB_COUNT-1:0] cycle_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if ((state_nxt == S_LOAD) && (state != S_LOAD)) begin
            cycle_cnt <= '0;
        end else if (pipe_enable && (cycle_cnt != {NB_COUNT{1'b1}})) begin
            cycle_cnt <= cycle_cnt + NB_COUNT'(1);
        end
    end

    assign cycle_count = cycle_cnt;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: directed per-cycle vectors push the
// expected post-edge state/count; a monitor pops and compares after each edge.
module tb_pipeline_sequencer;

    localparam logic [2:0] S_IDLE      = 3'b000;
    localparam logic [2:0] S_LOAD      = 3'b001;
    localparam logic [2:0] S_RUN       = 3'b010;
    localparam logic [2:0] S_STEP_EXEC = 3'b011;
    localparam logic [2:0] S_STEP_WAIT = 3'b100;
    localparam logic [2:0] S_DRAIN     = 3'b101;
    localparam logic [2:0] S_HALTED    = 3'b110;
    localparam logic [5:0] HALT = 6'b111111;
    localparam logic [5:0] NOP  = 6'b000000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_req = 1'b0;
    logic        load_done = 1'b0;
    logic        start_run = 1'b0;
    logic        step_req = 1'b0;
    logic [5:0]  opcode_id = 6'd0;
    logic        pipe_enable;
    logic        pc_halt;
    logic        halted;
    logic [2:0]  state_o;
    logic [31:0] cycle_count;

    pipeline_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .load_req    (load_req),
        .load_done   (load_done),
        .start_run   (start_run),
        .step_req    (step_req),
        .opcode_id   (opcode_id),
        .pipe_enable (pipe_enable),
        .pc_halt     (pc_halt),
        .halted      (halted),
        .state_o     (state_o),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] cnt;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_idx = 0;

    function automatic logic [31:0] cexp(input int v);
`ifdef CYCLE_COUNTER_EN
        return 32'(v);
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s vec%0d: got %0h expected %0h", name, idx, got, want);
        end
    endtask

    // Monitor: one expected record per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state_o", e.idx, 32'(state_o), 32'(e.st));
                check("pipe_enable", e.idx, 32'(pipe_enable),
                      32'((e.st == S_RUN) || (e.st == S_STEP_EXEC) || (e.st == S_DRAIN)));
                check("pc_halt", e.idx, 32'(pc_halt), 32'((e.st == S_DRAIN) || (e.st == S_HALTED)));
                check("halted", e.idx, 32'(halted), 32'(e.st == S_HALTED));
                check("cycle_count", e.idx, cycle_count, e.cnt);
            end
        end
    end

    // Apply inputs for one edge and push the state/count expected after it.
    task automatic cyc(input logic rst, input logic ld, input logic ldn, input logic sr,
                       input logic st, input logic [5:0] op, input logic [2:0] es, input int ec);
        exp_t e;
        reset     = rst;
        load_req  = ld;
        load_done = ldn;
        start_run = sr;
        step_req  = st;
        opcode_id = op;
        e.st  = es;
        e.cnt = cexp(ec);
        e.idx = vec_idx++;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    initial begin
        int guard;
        // Reset
        cyc(1, 0, 0, 0, 0, NOP, S_IDLE, 0);
        cyc(1, 1, 0, 1, 1, HALT, S_IDLE, 0);
        cyc(0, 0, 0, 0, 0, HALT, S_IDLE, 0);
        // Load: load_done three cycles after load_req; run/step/halt ignored
        cyc(0, 1, 0, 0, 0, NOP, S_LOAD, 0);
        cyc(0, 0, 0, 1, 0, NOP, S_LOAD, 0);
        cyc(0, 0, 0, 0, 1, HALT, S_LOAD, 0);
        cyc(0, 0, 1, 0, 0, NOP, S_IDLE, 0);
        // Run 10 cycles, HALT decoded in the 10th, then 4 drain cycles
        cyc(0, 0, 0, 1, 0, NOP, S_RUN, 0);
        cyc(0, 0, 0, 0, 0, NOP, S_RUN, 1);
        cyc(0, 0, 0, 0, 0, NOP, S_RUN, 2);
        cyc(0, 0, 0, 1, 1, NOP, S_RUN, 3);
        cyc(0, 0, 0, 0, 0, NOP, S_RUN, 4);
        cyc(0, 0, 0, 0, 0, NOP, S_RUN, 5);
        cyc(0, 0, 0, 0, 0, NOP, S_RUN, 6);
        cyc(0, 0, 0, 0, 0, NOP, S_RUN, 7);
        cyc(0, 0, 0, 0, 0, NOP, S_RUN, 8);
        cyc(0, 0, 0, 0, 0, NOP, S_RUN, 9);
        cyc(0, 0, 0, 0, 0, HALT, S_DRAIN, 10);
        cyc(0, 0, 0, 0, 0, HALT, S_DRAIN, 11);
        cyc(0, 1, 0, 1, 1, NOP, S_DRAIN, 12);
        cyc(0, 0, 0, 0, 0, NOP, S_DRAIN, 13);
        cyc(0, 0, 0, 0, 0, NOP, S_HALTED, 14);
        // Halted ignores everything except load_req
        cyc(0, 0, 0, 0, 1, NOP, S_HALTED, 14);
        cyc(0, 0, 0, 1, 0, HALT, S_HALTED, 14);
        cyc(0, 1, 0, 0, 0, NOP, S_LOAD, 0);
        cyc(0, 0, 1, 0, 0, NOP, S_IDLE, 0);
        // Three single steps spaced 5 cycles
        cyc(0, 0, 0, 0, 1, NOP, S_STEP_EXEC, 0);
        cyc(0, 0, 0, 0, 0, NOP, S_STEP_WAIT, 1);
        cyc(0, 0, 0, 0, 0, HALT, S_STEP_WAIT, 1);
        cyc(0, 0, 0, 0, 0, NOP, S_STEP_WAIT, 1);
        cyc(0, 0, 0, 0, 0, NOP, S_STEP_WAIT, 1);
        cyc(0, 0, 0, 0, 1, NOP, S_STEP_EXEC, 1);
        cyc(0, 0, 0, 0, 0, NOP, S_STEP_WAIT, 2);
        cyc(0, 0, 0, 0, 0, NOP, S_STEP_WAIT, 2);
        cyc(0, 0, 0, 0, 0, NOP, S_STEP_WAIT, 2);
        cyc(0, 0, 0, 0, 0, NOP, S_STEP_WAIT, 2);
        cyc(0, 0, 0, 0, 1, NOP, S_STEP_EXEC, 2);
        cyc(0, 0, 0, 0, 0, NOP, S_STEP_WAIT, 3);
        // Run wins over step in STEP_WAIT; pipe stays enabled
        cyc(0, 0, 0, 1, 1, NOP, S_RUN, 3);
        cyc(0, 0, 0, 0, 0, NOP, S_RUN, 4);
        cyc(0, 0, 0, 0, 1, NOP, S_RUN, 5);
        // Reset on the 2nd drain cycle, beating simultaneous requests
        cyc(0, 0, 0, 0, 0, HALT, S_DRAIN, 6);
        cyc(0, 0, 0, 0, 0, NOP, S_DRAIN, 7);
        cyc(1, 1, 0, 1, 1, HALT, S_IDLE, 0);
        cyc(0, 0, 0, 0, 0, NOP, S_IDLE, 0);
        // HALT decoded during a single step goes straight to drain
        cyc(0, 0, 0, 0, 1, NOP, S_STEP_EXEC, 0);
        cyc(0, 0, 0, 0, 0, HALT, S_DRAIN, 1);
        cyc(0, 0, 0, 0, 0, NOP, S_DRAIN, 2);
        cyc(0, 0, 0, 0, 0, NOP, S_DRAIN, 3);
        cyc(0, 0, 0, 0, 0, NOP, S_DRAIN, 4);
        cyc(0, 0, 0, 0, 0, NOP, S_HALTED, 5);
        cyc(0, 1, 0, 0, 0, NOP, S_LOAD, 0);
        cyc(0, 0, 1, 0, 0, NOP, S_IDLE, 0);
        // IDLE priority load > run > step, then run > step
        cyc(0, 1, 0, 1, 1, NOP, S_LOAD, 0);
        cyc(0, 0, 1, 0, 0, NOP, S_IDLE, 0);
        cyc(0, 0, 0, 1, 1, NOP, S_RUN, 0);
        cyc(1, 0, 0, 0, 0, NOP, S_IDLE, 0);
        // load_req overrides run and step in STEP_WAIT
        cyc(0, 0, 0, 0, 1, NOP, S_STEP_EXEC, 0);
        cyc(0, 0, 0, 0, 0, NOP, S_STEP_WAIT, 1);
        cyc(0, 1, 0, 1, 1, NOP, S_LOAD, 0);
        cyc(0, 0, 1, 0, 0, NOP, S_IDLE, 0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clock);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have parameter NB_OP, default 6, opcode width.
REQ-002 SHALL have parameter HALT_OPCODE, default 6'b111111, opcode that terminates execution.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, enabled cycles after HALT decode before stopping (range 1..15).
REQ-004 SHALL have parameter NB_COUNT, default 32, cycle counter width.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 Port: clock  in  1  sole clock; all logic on rising edge.
REQ-007 Port: reset  in  1  synchronous, active-high reset.
REQ-008 Port: load_req  in  1  pulse; program-load request from debug host.
REQ-009 Port: load_done  in  1  pulse; program load complete.
REQ-010 Port: start_run  in  1  pulse; enter continuous mode.
REQ-011 Port: step_req  in  1  pulse; execute one pipeline cycle.
REQ-012 Port: opcode_id  in  NB_OP  opcode currently decoded in ID stage.
REQ-013 Port: pipe_enable  out  1  global pipeline-register and PC enable.
REQ-014 Port: pc_halt  out  1  freeze PC, inject bubbles into IF/ID.
REQ-015 Port: halted  out  1  execution finished.
REQ-016 Port: state_o  out  3  current state encoding.
REQ-017 Port: cycle_count  out  NB_COUNT  enabled-cycle counter.

Function
REQ-018 SHALL implement states IDLE=000, LOAD=001, RUN=010, STEP_EXEC=011, STEP_WAIT=100, DRAIN=101, HALTED=110; state_o equals state register; all outputs registered or decoded from state only.
REQ-019 IDLE: pipe_enable=0; load_req -> LOAD, else start_run -> RUN, else step_req -> STEP_EXEC (priority load > run > step).
REQ-020 LOAD: pipe_enable=0, pc_halt=0; load_done -> IDLE; start_run/step_req ignored.
REQ-021 RUN: pipe_enable=1; opcode_id==HALT_OPCODE -> DRAIN, drain counter loaded DRAIN_CYCLES-1; start_run/step_req ignored.
REQ-022 STEP_EXEC: pipe_enable=1 for exactly one cycle; opcode_id==HALT_OPCODE -> DRAIN (counter loaded as REQ-021), else -> STEP_WAIT.
REQ-023 STEP_WAIT: pipe_enable=0; start_run -> RUN, else step_req -> STEP_EXEC (run wins if simultaneous); load_req -> LOAD overrides both.
REQ-024 DRAIN: pipe_enable=1, pc_halt=1; counter decrements each cycle; at counter==0 -> HALTED; all request inputs ignored; DRAIN lasts exactly DRAIN_CYCLES cycles.
REQ-025 HALTED: pipe_enable=0, pc_halt=1, halted=1; load_req -> LOAD (halted drops next cycle); other inputs ignored.
REQ-026 HALT opcode sampled only in RUN and STEP_EXEC; presence in other states SHALL have no effect.
REQ-027 Undefined state encodings SHALL return to IDLE on next cycle.

Reset
REQ-028 Reset SHALL force state IDLE, drain counter 0, cycle_count 0, pipe_enable=0, pc_halt=0, halted=0, state_o=000, from any state including mid-DRAIN.
REQ-029 Reset SHALL take priority over every request input in the same cycle.

Configuration
REQ-030 Macro CYCLE_COUNTER_EN defined: cycle_count increments by 1 on every cycle with pipe_enable=1, saturates at all-ones, clears to 0 on entry to LOAD.
REQ-031 Macro CYCLE_COUNTER_EN undefined: no counter register instantiated, cycle_count tied to 0; all other behaviour identical.

Verification
REQ-032 Reset; load_req, then load_done 3 cycles later -> state_o 001 then 000, pipe_enable stays 0, cycle_count 0.
REQ-033 start_run; opcode_id=6'b111111 on 10th RUN cycle -> pc_halt=1 for next 4 cycles, then halted=1, state_o=110, cycle_count=14 (CYCLE_COUNTER_EN).
REQ-034 step_req three times spaced 5 cycles -> exactly three single-cycle pipe_enable pulses, state alternating 011/100, cycle_count=3.
REQ-035 STEP_WAIT with step_req and start_run same cycle -> state RUN, pipe_enable continuously 1.
REQ-036 Reset asserted on 2nd DRAIN cycle -> next cycle state_o=000, pc_halt=0, halted=0, cycle_count=0.
REQ-037 HALTED, step_req/start_run pulsed -> no change; load_req -> LOAD, halted=0, cycle_count=0.
